pipelined_control_unit: RTL and testbench

Registered successor to the combinational main decoder for the 5-stage RV32I core. It decodes the opcode in Decode and drives the immediate selector there. It then carries the control bundle through ID/EX, EX/MEM and MEM/WB control registers, with hazard-unit stall/flush. It also decodes JALR, LUI and AUIPC, and counts retired instructions.

---
 rtl/pipelined_control_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Registered RV32I main decoder: decodes in Decode, carries controls through ID/EX, EX/MEM, MEM/WB.
// Optional macro ILLEGAL_TRAP_EN turns unknown opcodes into flagged bubbles instead of legacy R-type decode.
module pipelined_control_unit #(
    parameter int OPCODE_WIDTH    = 7,
    parameter int IMM_SRC_WIDTH   = 3,
    parameter int RESULTSRC_WIDTH = 2,
    parameter int ALU_OP_WIDTH    = 2,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [OPCODE_WIDTH-1:0]    opcode,
    input  logic                       ValidD,
    input  logic                       StallE,
    input  logic                       FlushE,
    output logic [IMM_SRC_WIDTH-1:0]   ImmSrcD,
    output logic                       RegWriteE,
    output logic                       MemWriteE,
    output logic                       BranchE,
    output logic                       JumpE,
    output logic                       JalrE,
    output logic                       ALUSrcE,
    output logic [1:0]                 ALUSrcAE,
    output logic [ALU_OP_WIDTH-1:0]    ALUOpE,
    output logic [RESULTSRC_WIDTH-1:0] ResultSrcE,
    output logic                       RegWriteM,
    output logic                       MemWriteM,
    output logic [RESULTSRC_WIDTH-1:0] ResultSrcM,
    output logic                       RegWriteW,
    output logic [RESULTSRC_WIDTH-1:0] ResultSrcW,
    output logic                       IllegalE,
    output logic [CNT_WIDTH-1:0]       instret
);

    localparam logic [OPCODE_WIDTH-1:0] OP_R      = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OP_I_ALU  = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = OPCODE_WIDTH'(7'b0100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = OPCODE_WIDTH'(7'b1101111);
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = OPCODE_WIDTH'(7'b1100111);
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = OPCODE_WIDTH'(7'b0110111);
    localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = OPCODE_WIDTH'(7'b0010111);

    typedef struct packed {
        logic                       reg_write;
        logic                       mem_write;
        logic                       branch;
        logic                       jump;
        logic                       jalr;
        logic                       alu_src;
        logic [1:0]                 alu_src_a;
        logic [ALU_OP_WIDTH-1:0]    alu_op;
        logic [RESULTSRC_WIDTH-1:0] result_src;
        logic                       illegal;
    } ex_ctrl_t;

    typedef struct packed {
        logic                       reg_write;
        logic                       mem_write;
        logic [RESULTSRC_WIDTH-1:0] result_src;
        logic                       illegal;
    } mem_ctrl_t;

    typedef struct packed {
        logic                       reg_write;
        logic [RESULTSRC_WIDTH-1:0] result_src;
        logic                       illegal;
    } wb_ctrl_t;

    ex_ctrl_t                 dec;
    ex_ctrl_t                 ctrl_d;
    logic [IMM_SRC_WIDTH-1:0] imm_src;

    ex_ctrl_t  ctrl_e;
    logic      valid_e;
    mem_ctrl_t ctrl_m;
    logic      valid_m;
    wb_ctrl_t  ctrl_w;
    logic      valid_w;

    // ------------------------------------------------------------------
    // Decode: opcode -> control bundle and immediate select
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every field gets a default first so no path leaves one unassigned (no latch).
        dec     = '0;
        imm_src = '0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_OP_WIDTH'(2'b10);
            end
            OP_I_ALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OP_WIDTH'(2'b01);
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RESULTSRC_WIDTH'(2'b01);
            end
            OP_STORE: begin
                imm_src       = IMM_SRC_WIDTH'(3'b001);
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                imm_src    = IMM_SRC_WIDTH'(3'b010);
                dec.branch = 1'b1;
                dec.alu_op = ALU_OP_WIDTH'(2'b11);
            end
            OP_JAL: begin
                imm_src        = IMM_SRC_WIDTH'(3'b011);
                dec.reg_write  = 1'b1;
                dec.result_src = RESULTSRC_WIDTH'(2'b10);
                dec.jump       = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RESULTSRC_WIDTH'(2'b10);
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
            end
            OP_LUI: begin
                imm_src       = IMM_SRC_WIDTH'(3'b100);
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_src_a = 2'b10;
            end
            OP_AUIPC: begin
                imm_src       = IMM_SRC_WIDTH'(3'b100);
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_src_a = 2'b01;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                // Bubble bundle that still travels as a valid (but uncounted) instruction.
                dec.illegal = 1'b1;
`else
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_OP_WIDTH'(2'b10);
`endif
            end
        endcase
    end

    assign ImmSrcD = imm_src;
    assign ctrl_d  = ValidD ? dec : '0;

    // ------------------------------------------------------------------
    // ID/EX: FlushE beats StallE beats load
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all stages sample pre-edge values.
        if (!rst_n) begin
            ctrl_e  <= '0;
            valid_e <= 1'b0;
        end else if (FlushE) begin
            ctrl_e  <= '0;
            valid_e <= 1'b0;
        end else if (!StallE) begin
            ctrl_e  <= ctrl_d;
            valid_e <= ValidD;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM and MEM/WB: free-running, never stalled
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_m  <= '0;
            valid_m <= 1'b0;
        end else begin
            ctrl_m.reg_write  <= ctrl_e.reg_write;
            ctrl_m.mem_write  <= ctrl_e.mem_write;
            ctrl_m.result_src <= ctrl_e.result_src;
            ctrl_m.illegal    <= ctrl_e.illegal;
            valid_m           <= valid_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_w  <= '0;
            valid_w <= 1'b0;
        end else begin
            ctrl_w.reg_write  <= ctrl_m.reg_write;
            ctrl_w.result_src <= ctrl_m.result_src;
            ctrl_w.illegal    <= ctrl_m.illegal;
            valid_w           <= valid_m;
        end
    end

    // Retirement counter: one count per valid, legal instruction leaving Writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (valid_w && !ctrl_w.illegal) begin
            instret <= instret + CNT_WIDTH'(1);
        end
    end

    assign RegWriteE  = ctrl_e.reg_write;
    assign MemWriteE  = ctrl_e.mem_write;
    assign BranchE    = ctrl_e.branch;
    assign JumpE      = ctrl_e.jump;
    assign JalrE      = ctrl_e.jalr;
    assign ALUSrcE    = ctrl_e.alu_src;
    assign ALUSrcAE   = ctrl_e.alu_src_a;
    assign ALUOpE     = ctrl_e.alu_op;
    assign ResultSrcE = ctrl_e.result_src;

    assign RegWriteM  = ctrl_m.reg_write;
    assign MemWriteM  = ctrl_m.mem_write;
    assign ResultSrcM = ctrl_m.result_src;

    assign RegWriteW  = ctrl_w.reg_write;
    assign ResultSrcW = ctrl_w.result_src;

`ifdef ILLEGAL_TRAP_EN
    assign IllegalE = ctrl_e.illegal;
`else
    assign IllegalE = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit (instret narrowed to 4 bits to reach the wrap point).
module tb_pipelined_control_unit;

    localparam int CW = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic          clk;
    logic          rst_n;
    logic [6:0]    opcode;
    logic          ValidD, StallE, FlushE;
    logic [2:0]    ImmSrcD;
    logic          RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE;
    logic [1:0]    ALUSrcAE, ALUOpE, ResultSrcE;
    logic          RegWriteM, MemWriteM;
    logic [1:0]    ResultSrcM;
    logic          RegWriteW;
    logic [1:0]    ResultSrcW;
    logic          IllegalE;
    logic [CW-1:0] instret;

    int compared   = 0;
    int mismatched = 0;

    pipelined_control_unit #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .ValidD(ValidD),
        .StallE(StallE), .FlushE(FlushE), .ImmSrcD(ImmSrcD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE),
        .ALUOpE(ALUOpE), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .IllegalE(IllegalE), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Execute-stage controls packed as {RegWrite,MemWrite,Branch,Jump,Jalr,ALUSrc,ALUSrcA,ALUOp,ResultSrc,Illegal}
    function automatic logic [31:0] ex_vec();
        return 32'({RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
                    ALUSrcAE, ALUOpE, ResultSrcE, IllegalE});
    endfunction

    function automatic logic [31:0] all_regs();
        return 32'({ex_vec(), RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW, instret});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = '0;
        ValidD = 1'b0;
        StallE = 1'b0;
        FlushE = 1'b0;
        #3;
        check("reset_all_zero", all_regs(), 32'h0);
        #9 rst_n = 1'b1;
        tick();

        // R-type through all stages
        opcode = OP_R; ValidD = 1'b1;
        tick();
        check("r_regwrite_e", 32'(RegWriteE), 32'h1);
        check("r_aluop_e", 32'(ALUOpE), 32'h2);
        check("r_alusrc_e", 32'(ALUSrcE), 32'h0);
        ValidD = 1'b0;
        tick();
        check("r_regwrite_m", 32'(RegWriteM), 32'h1);
        tick();
        check("r_regwrite_w", 32'(RegWriteW), 32'h1);
        check("r_instret_before", 32'(instret), 32'h0);
        tick();
        check("r_instret_after", 32'(instret), 32'h1);

        // LUI, AUIPC, JALR back to back
        opcode = OP_LUI; ValidD = 1'b1;
        #1 check("lui_immsrc", 32'(ImmSrcD), 32'h4);
        tick();
        check("lui_srca_e", 32'(ALUSrcAE), 32'h2);
        check("lui_alusrc_e", 32'(ALUSrcE), 32'h1);
        opcode = OP_AUIPC;
        #1 check("auipc_immsrc", 32'(ImmSrcD), 32'h4);
        tick();
        check("auipc_srca_e", 32'(ALUSrcAE), 32'h1);
        opcode = OP_JALR;
        #1 check("jalr_immsrc", 32'(ImmSrcD), 32'h0);
        tick();
        check("jalr_srca_e", 32'(ALUSrcAE), 32'h0);
        check("jalr_jump_jalr_rsrc", 32'({JumpE, JalrE, ResultSrcE}), 32'b1110);
        ValidD = 1'b0;
        repeat (4) tick();
        check("seq_instret", 32'(instret), 32'h4);

        // Load held by StallE for two cycles, then flush+stall
        opcode = OP_LOAD; ValidD = 1'b1;
        tick();
        check("ld_rsrc_e_c1", 32'(ResultSrcE), 32'h1);
        ValidD = 1'b0; StallE = 1'b1;
        tick();
        check("ld_rsrc_e_c2", 32'(ResultSrcE), 32'h1);
        check("ld_rsrc_m_c2", 32'(ResultSrcM), 32'h1);
        tick();
        check("ld_rsrc_e_c3", 32'(ResultSrcE), 32'h1);
        FlushE = 1'b1;
        tick();
        check("flush_stall_ex_zero", ex_vec(), 32'h0);
        check("flush_rsrc_m_copy", 32'(ResultSrcM), 32'h1);
        FlushE = 1'b0; StallE = 1'b0;
        repeat (4) tick();
        // three stalled copies of the load reach Writeback
        check("ld_instret", 32'(instret), 32'h7);

        // Store followed by three bubbles
        opcode = OP_STORE; ValidD = 1'b1;
        #1 check("st_immsrc", 32'(ImmSrcD), 32'h1);
        tick();
        check("st_memwrite_e", 32'({MemWriteE, RegWriteE}), 32'b10);
        check("st_memwrite_m_pre", 32'(MemWriteM), 32'h0);
        ValidD = 1'b0;
        tick();
        check("st_memwrite_m_1", 32'(MemWriteM), 32'h1);
        tick();
        check("st_memwrite_m_2", 32'(MemWriteM), 32'h0);
        tick();
        check("st_memwrite_m_3", 32'(MemWriteM), 32'h0);
        check("st_instret", 32'(instret), 32'h8);

        // I-ALU, Branch, JAL, then unknown opcode
        opcode = OP_I_ALU; ValidD = 1'b1;
        tick();
        check("iop_ex", ex_vec(), 32'b1_0_0_0_0_1_00_01_00_0);
        opcode = OP_BRANCH;
        #1 check("br_immsrc", 32'(ImmSrcD), 32'h2);
        tick();
        check("br_ex", ex_vec(), 32'b0_0_1_0_0_0_00_11_00_0);
        opcode = OP_JAL;
        #1 check("jal_immsrc", 32'(ImmSrcD), 32'h3);
        tick();
        check("jal_ex", ex_vec(), 32'b1_0_0_1_0_0_00_00_10_0);
        opcode = OP_BAD;
        tick();
`ifdef ILLEGAL_TRAP_EN
        check("bad_ex_trap", ex_vec(), 32'h1);
`else
        check("bad_ex_legacy", ex_vec(), 32'b1_0_0_0_0_0_00_10_00_0);
`endif
        ValidD = 1'b0;
        tick();
        check("bad_illegal_clears", 32'(IllegalE), 32'h0);
        repeat (3) tick();
`ifdef ILLEGAL_TRAP_EN
        check("bad_instret_trap", 32'(instret), 32'd11);
`else
        check("bad_instret_legacy", 32'(instret), 32'd12);
`endif

        // Asynchronous reset with a full pipeline
        opcode = OP_R; ValidD = 1'b1;
        repeat (3) tick();
        check("pre_rst_full", 32'({RegWriteE, RegWriteM, RegWriteW}), 32'b111);
        #2 rst_n = 1'b0;
        #1 check("async_rst_all_zero", all_regs(), 32'h0);
        ValidD = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_idle", all_regs(), 32'h0);

        // instret wrap: 15 retires, then one more
        opcode = OP_R; ValidD = 1'b1;
        repeat (15) tick();
        ValidD = 1'b0;
        repeat (4) tick();
        check("wrap_instret_max", 32'(instret), 32'hF);
        ValidD = 1'b1;
        tick();
        ValidD = 1'b0;
        repeat (4) tick();
        check("wrap_instret_zero", 32'(instret), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
